// File: rtl/tdm_demux_1_4.sv
// Receive side of the 4:1 TDM link: rebuilds four-channel frames from a slot stream
// keyed on a slot-0 sync marker, and flags lost or misplaced sync.
module tdm_demux_1_4 #(
    parameter int W = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           sync,
    input  logic [W-1:0]   din,
    output logic [4*W-1:0] o,
    output logic [1:0]     sel,
    output logic           frame_valid,
    output logic           sync_err,
    output logic           locked
);

    typedef enum logic {
        HUNT,
        LOCKED
    } state_t;

    state_t             state, state_nxt;
    logic [1:0]         sel_nxt;
    logic [2:0][W-1:0]  shadow, shadow_nxt;
    logic [4*W-1:0]     o_nxt;
    logic               frame_valid_nxt, sync_err_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= HUNT;
            sel         <= 2'd0;
            shadow      <= '0;
            o           <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            state       <= state_nxt;
            sel         <= sel_nxt;
            shadow      <= shadow_nxt;
            o           <= o_nxt;
            frame_valid <= frame_valid_nxt;
            sync_err    <= sync_err_nxt;
        end
    end

    // A sync beat always restarts the frame at slot 0; only slot 3 ever publishes to o.
    always_comb begin
        state_nxt       = state;
        sel_nxt         = sel;
        shadow_nxt      = shadow;
        o_nxt           = o;
        frame_valid_nxt = 1'b0;
        sync_err_nxt    = 1'b0;
        if (en) begin
            case (state)
                HUNT: begin
                    if (sync) begin
                        shadow_nxt[0] = din;
                        sel_nxt       = 2'd1;
                        state_nxt     = LOCKED;
                    end
                end
                LOCKED: begin
                    if (sync) begin
                        sync_err_nxt  = (sel != 2'd0);
                        shadow_nxt[0] = din;
                        sel_nxt       = 2'd1;
                    end else begin
                        case (sel)
                            2'd0: begin
                                sync_err_nxt = 1'b1;
                                state_nxt    = HUNT;
                                sel_nxt      = 2'd0;
                            end
                            2'd1: begin
                                shadow_nxt[1] = din;
                                sel_nxt       = 2'd2;
                            end
                            2'd2: begin
                                shadow_nxt[2] = din;
                                sel_nxt       = 2'd3;
                            end
                            default: begin
                                o_nxt           = {din, shadow[2], shadow[1], shadow[0]};
                                frame_valid_nxt = 1'b1;
                                sel_nxt         = 2'd0;
                            end
                        endcase
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_tdm_demux_1_4.sv
// Directed bench for tdm_demux_1_4 (W=1); frame/sync_err events are checked by a
// queue-based monitor, state outputs by direct checks after each beat.
module tb_tdm_demux_1_4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       sync;
    logic [0:0] din;
    logic [3:0] o;
    logic [1:0] sel;
    logic       frame_valid;
    logic       sync_err;
    logic       locked;

    typedef struct {
        logic       is_err;
        logic [3:0] o;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    tdm_demux_1_4 #(.W(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .sync        (sync),
        .din         (din),
        .o           (o),
        .sel         (sel),
        .frame_valid (frame_valid),
        .sync_err    (sync_err),
        .locked      (locked)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic e, input logic s, input logic d);
        en   = e;
        sync = s;
        din  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic pushFrame(input logic [3:0] v);
        exp_t x;
        x.is_err = 1'b0;
        x.o      = v;
        sb.push_back(x);
    endtask

    task automatic pushErr(input logic [3:0] v);
        exp_t x;
        x.is_err = 1'b1;
        x.o      = v;
        sb.push_back(x);
    endtask

    // Every pulse the DUT raises must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (frame_valid && sync_err) begin
            total++;
            bad++;
            $display("[TB] FAIL pulse_overlap: got both pulses expected at most one");
        end else if (frame_valid || sync_err) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_event: got fv=%0b err=%0b expected none", frame_valid, sync_err);
            end else begin
                exp_t x;
                x = sb.pop_front();
                checkOutput("event_kind", {31'd0, sync_err}, {31'd0, x.is_err});
                checkOutput("event_o", {28'd0, o}, {28'd0, x.o});
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("reset_o", {28'd0, o}, 32'd0);
        checkOutput("reset_sel", {30'd0, sel}, 32'd0);
        checkOutput("reset_locked", {31'd0, locked}, 32'd0);
        checkOutput("reset_fv", {31'd0, frame_valid}, 32'd0);
        checkOutput("reset_err", {31'd0, sync_err}, 32'd0);
        rst = 1'b0;

        // Continuous beats: frame 1,1,1,0 then back-to-back frame 0,1,0,1
        pushFrame(4'b0111);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("t2_sel1", {30'd0, sel}, 32'd1);
        checkOutput("t2_locked", {31'd0, locked}, 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("t2_o_hidden", {28'd0, o}, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("t2_o", {28'd0, o}, 32'h7);
        checkOutput("t2_fv", {31'd0, frame_valid}, 32'd1);
        checkOutput("t2_sel_wrap", {30'd0, sel}, 32'd0);
        pushFrame(4'b1010);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("t2_fv_drop", {31'd0, frame_valid}, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("t2_o2", {28'd0, o}, 32'hA);

        // en toggling: frame 1,1,1,0 with idle cycles in between
        pushFrame(4'b0111);
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t3_sel_hold", {30'd0, sel}, 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("t3_sel_hold2", {30'd0, sel}, 32'd2);
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("t3_o_hold", {28'd0, o}, 32'hA);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("t3_o", {28'd0, o}, 32'h7);
        checkOutput("t3_fv", {31'd0, frame_valid}, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t3_fv_idle", {31'd0, frame_valid}, 32'd0);

        // Misplaced sync at sel=2 restarts the frame at slot 0
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        pushErr(4'b0111);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("t4_err", {31'd0, sync_err}, 32'd1);
        checkOutput("t4_sel", {30'd0, sel}, 32'd1);
        checkOutput("t4_locked", {31'd0, locked}, 32'd1);
        checkOutput("t4_o_keep", {28'd0, o}, 32'h7);
        pushFrame(4'b0101);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("t4_o", {28'd0, o}, 32'h5);

        // Missing sync at slot 0 drops to HUNT until the next sync
        pushErr(4'b0101);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("t5_locked", {31'd0, locked}, 32'd0);
        checkOutput("t5_sel", {30'd0, sel}, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("t5_hunt_sel", {30'd0, sel}, 32'd0);
        checkOutput("t5_hunt_locked", {31'd0, locked}, 32'd0);
        pushFrame(4'b1100);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("t5_relock", {31'd0, locked}, 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("t5_o", {28'd0, o}, 32'hC);

        // Reset mid-frame clears o and returns to HUNT
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1);
        rst = 1'b0;
        checkOutput("t6_o", {28'd0, o}, 32'd0);
        checkOutput("t6_sel", {30'd0, sel}, 32'd0);
        checkOutput("t6_locked", {31'd0, locked}, 32'd0);
        pushFrame(4'b0101);
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("t6_o2", {28'd0, o}, 32'h5);

        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("sb_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
